// File: rtl/dff_pipe_if.sv
// Handshake/data bundle for dff_pipe: producer side, consumer side, flush and occupancy.
// master = environment driving the pipe, slave = the pipe itself.
interface dff_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output flush, in_valid, d, out_ready,
        input  in_ready, out_valid, q, occupancy
    );

    modport slave (
        input  flush, in_valid, d, out_ready,
        output in_ready, out_valid, q, occupancy
    );
endinterface

// File: rtl/dff_pipe.sv
// WIDTH x DEPTH elastic register pipeline with per-stage valid, bubble collapse and flush.
// Optional occupancy counter enabled by defining DFF_PIPE_OCC_EN (port reads 0 otherwise).
module dff_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    dff_pipe_if.slave   bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;

    // adv[i] is true when any hole exists at or above stage i, or the consumer takes the head.
    // A scalar running term avoids a self-referencing vector chain.
    always_comb begin
        logic hole;
        adv  = '0;
        hole = !v[DEPTH-1] | bus.out_ready;
        adv[DEPTH-1] = hole;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            int unsigned i;
            i      = DEPTH - 1 - k;
            hole   = hole | !v[i];
            adv[i] = hole;
        end
    end

    assign bus.in_ready  = adv[0] & !bus.flush;
    assign bus.out_valid = v[DEPTH-1];
    assign bus.q         = data[DEPTH-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data[i] <= '0;
            end
        end else if (bus.flush) begin
            v <= '0;
        end else begin
            if (adv[0]) begin
                data[0] <= bus.d;
                v[0]    <= bus.in_valid & bus.in_ready;
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (adv[i]) begin
                    data[i] <= data[i-1];
                    v[i]    <= v[i-1];
                end
            end
        end
    end

`ifdef DFF_PIPE_OCC_EN
    logic [OCC_W-1:0] occ;
    logic             xfer_in;
    logic             xfer_out;

    assign xfer_in  = bus.in_valid & bus.in_ready;
    assign xfer_out = v[DEPTH-1] & bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ <= '0;
        end else if (bus.flush) begin
            occ <= '0;
        end else if (xfer_in && !xfer_out) begin
            occ <= occ + OCC_W'(1);
        end else if (xfer_out && !xfer_in) begin
            occ <= occ - OCC_W'(1);
        end
    end

    assign bus.occupancy = occ;
`else
    assign bus.occupancy = '0;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: beat-position queue model, per-cycle compare, directed + random stimulus.
module tb_dff_pipe;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic clk;
    logic reset;

    dff_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: in-flight beats oldest first, each with its stage position (0 = input, DEPTH-1 = output).
    int               mpos [$];
    logic [WIDTH-1:0] mdat [$];
    int               np   [$];
    bit               rdy_m;

    function automatic void plan();
        int prev;
        np   = {};
        prev = DEPTH + 1;
        for (int k = 0; k < mpos.size(); k++) begin
            int p;
            int n;
            p = mpos[k];
            if (k == 0) n = (p < DEPTH - 1) ? p + 1 : (bus.out_ready ? DEPTH : p);
            else        n = (prev > p + 1) ? p + 1 : p;
            np.push_back(n);
            prev = n;
        end
        rdy_m = !bus.flush && (np.size() == 0 || np[np.size()-1] != 0);
    endfunction

    function automatic int exp_occ();
`ifdef DFF_PIPE_OCC_EN
        return mpos.size();
`else
        return 0;
`endif
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mpos = {};
            mdat = {};
        end else if (bus.flush) begin
            mpos = {};
            mdat = {};
        end else begin
            plan();
            mpos = {};
            for (int k = 0; k < np.size(); k++) begin
                if (np[k] == DEPTH) void'(mdat.pop_front());
                else mpos.push_back(np[k]);
            end
            if (bus.in_valid && rdy_m) begin
                mpos.push_back(0);
                mdat.push_back(bus.d);
            end
        end
    end

    always @(negedge clk) begin
        bit ov;
        plan();
        ov = (mpos.size() > 0) && (mpos[0] == DEPTH - 1);
        chk("in_ready", longint'(bus.in_ready), longint'(rdy_m));
        chk("out_valid", longint'(bus.out_valid), longint'(ov));
        if (ov) chk("q", longint'(bus.q), longint'(mdat[0]));
        chk("occupancy", longint'(bus.occupancy), longint'(exp_occ()));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [WIDTH-1:0] dv, input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.d         = dv;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    task automatic chk_occ(input string name, input int n);
`ifdef DFF_PIPE_OCC_EN
        chk(name, longint'(bus.occupancy), longint'(n));
`else
        chk(name, longint'(bus.occupancy), 0);
        if (n < 0) $display("unexpected occupancy argument");
`endif
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b1, 8'hFF, 1'b1, 1'b0);

        // Reset held with traffic offered
        step(); step();
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_q", longint'(bus.q), 0);
        chk_occ("rst_occ", 0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 chk("rst_in_ready", longint'(bus.in_ready), 1);
        step();

        // Streaming
        drive(1'b1, 8'h11, 1'b1, 1'b0); step();
        drive(1'b1, 8'h22, 1'b1, 1'b0); step();
        drive(1'b1, 8'h33, 1'b1, 1'b0); step();
        drive(1'b0, 8'h00, 1'b1, 1'b0); step();
        chk("stream_v0", longint'(bus.out_valid), 1);
        chk("stream_q0", longint'(bus.q), 8'h11);
        step(); chk("stream_q1", longint'(bus.q), 8'h22);
        step(); chk("stream_q2", longint'(bus.q), 8'h33);
        step(); chk("stream_end", longint'(bus.out_valid), 0);

        // Backpressure
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
            #1 chk("bp_accept", longint'(bus.in_ready), 1);
            step();
        end
        drive(1'b1, 8'hA4, 1'b0, 1'b0);
        #1 chk("bp_full_ready", longint'(bus.in_ready), 0);
        chk_occ("bp_full_occ", 4);
        step();
        drive(1'b1, 8'hA4, 1'b1, 1'b0);
        #1 chk("bp_q_a0", longint'(bus.q), 8'hA0);
        step();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp_q_a1", longint'(bus.q), 8'hA1);
        step(); chk("bp_q_a2", longint'(bus.q), 8'hA2);
        step(); chk("bp_q_a3", longint'(bus.q), 8'hA3);
        step(); chk("bp_q_a4", longint'(bus.q), 8'hA4);
        step(); chk("bp_drain", longint'(bus.out_valid), 0);
        chk_occ("bp_drain_occ", 0);

        // Bubble collapse
        drive(1'b1, 8'h5A, 1'b0, 1'b0); step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (5) step();
        drive(1'b1, 8'h5B, 1'b0, 1'b0); step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk_occ("bub_occ", 2);
        repeat (2) step();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        #1 chk("bub_q_5a", longint'(bus.q), 8'h5A);
        step();
        chk("bub_v_5b", longint'(bus.out_valid), 1);
        chk("bub_q_5b", longint'(bus.q), 8'h5B);
        step();

        // Flush with a full pipe
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0); step();
        end
        drive(1'b1, 8'hC3, 1'b0, 1'b1);
        #1 chk("fl_in_ready", longint'(bus.in_ready), 0);
        step();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fl_out_valid", longint'(bus.out_valid), 0);
        chk_occ("fl_occ", 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("fl_no_c3", longint'(bus.out_valid), 0);
        end

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'hD1 + 8'(i), 1'b0, 1'b0); step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("arst_out_valid", longint'(bus.out_valid), 0);
        chk_occ("arst_occ", 0);
        #2 reset = 1'b1;
        step();
        drive(1'b1, 8'hE1, 1'b1, 1'b0); step();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step(); step();
        chk("arst_early", longint'(bus.out_valid), 0);
        step();
        chk("arst_lat_v", longint'(bus.out_valid), 1);
        chk("arst_lat_q", longint'(bus.q), 8'hE1);
        step();

        // Randomized traffic with occasional flush
        for (int c = 0; c < 3000; c++) begin
            drive(logic'($urandom_range(0, 3) != 0), WIDTH'($urandom),
                  logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 39) == 0));
            step();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (DEPTH + 2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline with per-stage valid bits and valid/ready handshake on both sides.
- Stalled stages hold their data. Empty stages are filled from upstream (bubble collapse).
- Adds a synchronous flush and an occupancy count.
- Sits between producer and consumer blocks as a retiming/elastic stage.

Parameters:
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 4, number of register stages (>=1)
- OCC_W, $clog2(DEPTH+1), occupancy port width (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of all stages, active-high
- in_valid  input  1  upstream beat present
- in_ready  output  1  pipeline can accept a beat this cycle
- d  input  WIDTH  upstream data
- out_valid  output  1  last stage holds a beat
- out_ready  input  1  downstream accepts a beat
- q  output  WIDTH  last-stage data
- occupancy  output  OCC_W  number of valid stages

Behaviour:
- Storage: stage i (0..DEPTH-1) = data[i] (WIDTH), v[i] (1). Stage 0 is the input stage; stage DEPTH-1 drives q/out_valid.
- Reset (reset=0, asynchronous, no clock needed): all v[i]=0, all data[i]=0, occupancy=0. Hence out_valid=0, q=0. in_ready=1 once reset=1 and flush=0.
- Move conditions (combinational, computed from the last stage back to stage 0):
  - last stage: adv[DEPTH-1] = !v[DEPTH-1] | out_ready
  - other stages: adv[i] = !v[i] | adv[i+1]
  - in_ready = adv[0] & !flush
- Per edge, for each stage i with adv[i]=1:
  - stage 0 loads d and sets v[0] = in_valid & in_ready.
  - stage i>0 loads data[i-1] and sets v[i] = v[i-1].
- A stage with adv[i]=0 holds data and valid.
- Data is not qualified by valid: invalid stages may carry stale data, but q is only meaningful when out_valid=1.
- Handshakes:
  - Transfer in: in_valid & in_ready at an edge.
  - Transfer out: out_valid & out_ready at an edge.
  - in_ready may depend combinationally on out_ready. There is no combinational path from in_valid or d to out_valid or q.
- Latency:
  - Beat accepted at edge k with no stall appears on q/out_valid after edge k+DEPTH-1 (DEPTH register stages).
  - Throughput is 1 beat/cycle.
- Backpressure: with out_ready=0, up to DEPTH beats are absorbed, then in_ready=0. Order is preserved; no beat is lost or duplicated.
- Flush:
  - With flush=1 at an edge, all v[i] become 0 and data is unchanged.
  - in_ready=0 while flush=1, so no beat is accepted that cycle.
  - An out_valid & out_ready transfer in a flush cycle is still counted by the consumer. The flushed contents are discarded.
- Occupancy:
  - Registered; always equals the popcount of v.
  - +1 on transfer in, -1 on transfer out, unchanged when both or neither occur, 0 after flush or reset.
- DEPTH=1: a single register stage with in_ready = !v[0] | out_ready.

Optional Feature:
- Macro DFF_PIPE_OCC_EN.
- Defined: occupancy counter is built as specified above.
- Undefined: no counter logic; occupancy port is tied to 0. All other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1, d=8'hFF -> out_valid=0, q=8'h00, occupancy=0. Release reset -> in_ready=1 before the next edge.
- Streaming (WIDTH=8, DEPTH=4, out_ready=1): accept 8'h11, 8'h22, 8'h33 on consecutive edges k, k+1, k+2 -> q=8'h11 with out_valid=1 after edge k+3, then 8'h22, 8'h33 on the following cycles with no gaps.
- Backpressure: out_ready=0, offer 8'hA0..8'hA4 -> A0..A3 accepted, in_ready=0 while A4 is offered, occupancy=4. Raise out_ready -> q sequence A0, A1, A2, A3, A4, occupancy returns to 0.
- Bubble collapse: out_ready=0, accept 8'h5A, idle 5 cycles, accept 8'h5B -> occupancy=2. Raise out_ready -> 8'h5A then 8'h5B on consecutive cycles.
- Flush: with 4 valid stages and in_valid=1, d=8'hC3, out_ready=0, pulse flush for 1 cycle -> in_ready=0 during the pulse. After the edge: out_valid=0, occupancy=0, and 8'hC3 never appears on q.
- Async reset mid-operation: with 3 beats in flight, drive reset=0 midway between edges -> out_valid=0 and occupancy=0 immediately, without a clock edge. After release, the next accepted beat exits after DEPTH-1 further edges.
